game_flow_controller: RTL and testbench

- Top-level sequencer for the breakout game. It sits between the VGA sync generator, the paddle/ball/brick datapath and the keyboard/button front end.
- Derives a per-frame tick from the vertical sync.
- Runs the game state machine (idle, serve, play, pause, over, win).
- Issues a ball-motion enable and a serve/reposition strobe to the datapath.
- Keeps lives and a 4-digit BCD score for the 7-segment scanner.

---
 rtl/game_flow_controller_if.sv | 35 +++
 rtl/game_flow_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_game_flow_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_controller_if.sv
// ============================================================================
// Module      : game_flow_controller_if
// Description : Input/output bundle between the breakout game flow controller
//               and the sync generator, datapath and keyboard front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_flow_controller_if;
    logic       v_sync;
    logic       key_start;
    logic       key_pause;
    logic       ball_lost;
    logic       brick_hit;
    logic [5:0] bricks_left;
    logic [2:0] state;
    logic       move_tick;
    logic       serve_load;
    logic [1:0] lives;
    logic [15:0] score_bcd;
    logic       game_end;

    // The environment (sync generator, datapath, keys) drives the inputs.
    modport master (
        output v_sync, key_start, key_pause, ball_lost, brick_hit, bricks_left,
        input  state, move_tick, serve_load, lives, score_bcd, game_end
    );

    modport slave (
        input  v_sync, key_start, key_pause, ball_lost, brick_hit, bricks_left,
        output state, move_tick, serve_load, lives, score_bcd, game_end
    );
endinterface

`default_nettype wire

// File: rtl/game_flow_controller.sv
// ============================================================================
// Module      : game_flow_controller
// Description : Breakout game sequencer. Derives a frame tick from v_sync and
//               runs the idle/serve/play/pause/over/win flow, lives and a
//               saturating 4-digit BCD score. Optional macro EXTRA_LIFE_EN
//               awards a life each time the score rolls over a hundred.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_flow_controller #(
    parameter int LIVES_INIT   = 3,
    parameter int FRAME_DIV    = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  wire                    clock,
    input  wire                    reset,
    game_flow_controller_if.slave  bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SERVE = 3'd1;
    localparam logic [2:0] c_PLAY  = 3'd2;
    localparam logic [2:0] c_PAUSE = 3'd3;
    localparam logic [2:0] c_OVER  = 3'd4;
    localparam logic [2:0] c_WIN   = 3'd5;

    localparam logic [1:0] c_LIVES_INIT = 2'(LIVES_INIT);
    localparam logic [3:0] c_DIV_LAST   = 4'(FRAME_DIV - 1);
    localparam logic [7:0] c_SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [15:0] c_SCORE_MAX = 16'h9999;

    logic [2:0]  r_state;
    logic [2:0]  w_stateNext;
    logic        r_vsyncPrev;
    logic        w_frameTick;
    logic [7:0]  r_serveCnt;
    logic [7:0]  w_serveCntNext;
    logic [3:0]  r_frameDiv;
    logic [3:0]  w_frameDivNext;
    logic [1:0]  r_lives;
    logic [1:0]  w_livesNext;
    logic [15:0] r_score;
    logic [15:0] w_scoreNext;
    logic        r_moveTick;
    logic        w_moveTickNext;
    logic        r_serveLoad;
    logic        w_serveLoadNext;
    logic        r_gameEnd;
    logic        w_gameEndNext;
    logic        w_lossValid;
    logic [1:0]  w_livesAfterLoss;
    logic [1:0]  w_livesGain;
    logic        w_award;

    // v_sync shares this clock domain, so one history flop is enough.
    assign w_frameTick = r_vsyncPrev & ~bus.v_sync;
    assign w_lossValid = (r_state == c_PLAY) && bus.ball_lost && (r_lives != 2'd0);

    function automatic logic [15:0] bcdInc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (res[d*4 +: 4] == 4'd9) begin
                    res[d*4 +: 4] = 4'd0;
                end else begin
                    res[d*4 +: 4] = res[d*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

`ifdef EXTRA_LIFE_EN
    // A hundred boundary is crossed when the low two digits roll from 99.
    assign w_award          = (r_state == c_PLAY) && bus.brick_hit &&
                              (r_score[7:0] == 8'h99) && (r_score != c_SCORE_MAX);
    // Loss is applied before the award; r_lives >= 1 here so no overflow.
    assign w_livesAfterLoss = (r_lives - 2'd1) + {1'b0, w_award};
    assign w_livesGain      = (r_lives == 2'd3) ? 2'd3 : r_lives + 2'd1;
`else
    assign w_award          = 1'b0;
    assign w_livesAfterLoss = r_lives - 2'd1;
    assign w_livesGain      = r_lives;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.key_start) w_stateNext = c_SERVE;
            end
            c_SERVE: begin
                if (w_frameTick && (r_serveCnt == c_SERVE_LAST)) w_stateNext = c_PLAY;
            end
            c_PLAY: begin
                if (w_lossValid) begin
                    w_stateNext = (w_livesAfterLoss == 2'd0) ? c_OVER : c_SERVE;
                end else if (bus.bricks_left == 6'd0) begin
                    w_stateNext = c_WIN;
                end else if (bus.key_pause) begin
                    w_stateNext = c_PAUSE;
                end
            end
            c_PAUSE: begin
                if (bus.key_pause) w_stateNext = c_PLAY;
            end
            c_OVER, c_WIN: begin
                if (bus.key_start) w_stateNext = c_IDLE;
            end
            default: w_stateNext = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_livesNext     = r_lives;
        w_scoreNext     = r_score;
        w_serveCntNext  = r_serveCnt;
        w_frameDivNext  = r_frameDiv;
        w_moveTickNext  = 1'b0;
        w_serveLoadNext = 1'b0;
        w_gameEndNext   = (w_stateNext == c_OVER) || (w_stateNext == c_WIN);
        case (r_state)
            c_IDLE: begin
                if (bus.key_start) begin
                    w_livesNext     = c_LIVES_INIT;
                    w_scoreNext     = 16'h0000;
                    w_serveLoadNext = 1'b1;
                    w_serveCntNext  = 8'd0;
                end
            end
            c_SERVE: begin
                if (w_frameTick) begin
                    if (r_serveCnt == c_SERVE_LAST) begin
                        w_frameDivNext = 4'd0;
                    end else begin
                        w_serveCntNext = r_serveCnt + 8'd1;
                    end
                end
            end
            c_PLAY: begin
                if (bus.brick_hit && (r_score != c_SCORE_MAX)) begin
                    w_scoreNext = bcdInc(r_score);
                end
                if (w_frameTick) begin
                    if (r_frameDiv == c_DIV_LAST) begin
                        w_frameDivNext = 4'd0;
                        // A tick whose frame also leaves PLAY is dropped.
                        w_moveTickNext = (w_stateNext == c_PLAY);
                    end else begin
                        w_frameDivNext = r_frameDiv + 4'd1;
                    end
                end
                if (w_lossValid) begin
                    w_livesNext = w_livesAfterLoss;
                    if (w_stateNext == c_SERVE) begin
                        w_serveLoadNext = 1'b1;
                        w_serveCntNext  = 8'd0;
                    end
                end else if (w_award) begin
                    w_livesNext = w_livesGain;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vsyncPrev <= 1'b1;
            r_serveCnt  <= 8'd0;
            r_frameDiv  <= 4'd0;
            r_lives     <= 2'd0;
            r_score     <= 16'h0000;
            r_moveTick  <= 1'b0;
            r_serveLoad <= 1'b0;
            r_gameEnd   <= 1'b0;
        end else begin
            r_vsyncPrev <= bus.v_sync;
            r_serveCnt  <= w_serveCntNext;
            r_frameDiv  <= w_frameDivNext;
            r_lives     <= w_livesNext;
            r_score     <= w_scoreNext;
            r_moveTick  <= w_moveTickNext;
            r_serveLoad <= w_serveLoadNext;
            r_gameEnd   <= w_gameEndNext;
        end
    end

    assign bus.state      = r_state;
    assign bus.move_tick  = r_moveTick;
    assign bus.serve_load = r_serveLoad;
    assign bus.lives      = r_lives;
    assign bus.score_bcd  = r_score;
    assign bus.game_end   = r_gameEnd;

endmodule

`default_nettype wire

// File: tb/tb_game_flow_controller.sv
// ============================================================================
// Module      : tb_game_flow_controller
// Description : Directed self-checking bench for game_flow_controller with
//               LIVES_INIT=3, FRAME_DIV=2, SERVE_FRAMES=60.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_flow_controller;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   ticks = 0;
    logic [1:0] expLives;

    always #5 clock = ~clock;

    game_flow_controller_if bus ();

    game_flow_controller #(
        .LIVES_INIT  (3),
        .FRAME_DIV   (2),
        .SERVE_FRAMES(60)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One v_sync falling edge; a move_tick must appear only in the first cycle.
    task automatic vsEdge();
        bus.v_sync = 1'b0;
        step();
        if (bus.move_tick) ticks++;
        bus.v_sync = 1'b1;
        step();
        check("tick_width", 16'(bus.move_tick), 16'h0);
    endtask

    task automatic hits(input int n);
        bus.brick_hit = 1'b1;
        repeat (n) step();
        bus.brick_hit = 1'b0;
    endtask

    task automatic serveToPlay();
        ticks = 0;
        repeat (59) vsEdge();
        check("serve_59", 16'(bus.state), 16'h1);
        vsEdge();
        check("play_60", 16'(bus.state), 16'h2);
        check("serve_ticks", 16'(ticks), 16'h0);
    endtask

    task automatic startGame();
        bus.key_start = 1'b1;
        step();
        bus.key_start = 1'b0;
        check("start_state", 16'(bus.state), 16'h1);
        check("start_lives", 16'(bus.lives), 16'h3);
        check("start_load", 16'(bus.serve_load), 16'h1);
        check("start_score", bus.score_bcd, 16'h0000);
        step();
        check("load_width", 16'(bus.serve_load), 16'h0);
    endtask

    initial begin
        bus.v_sync      = 1'b1;
        bus.key_start   = 1'b0;
        bus.key_pause   = 1'b0;
        bus.ball_lost   = 1'b0;
        bus.brick_hit   = 1'b0;
        bus.bricks_left = 6'd20;
        repeat (3) step();
        check("rst_state", 16'(bus.state), 16'h0);
        check("rst_lives", 16'(bus.lives), 16'h0);
        check("rst_score", bus.score_bcd, 16'h0000);
        check("rst_tick", 16'(bus.move_tick), 16'h0);
        check("rst_end", 16'(bus.game_end), 16'h0);
        reset = 1'b1;
        step();

        startGame();
        // Ignored inputs in SERVE
        bus.ball_lost = 1'b1;
        bus.key_pause = 1'b1;
        step();
        bus.ball_lost = 1'b0;
        bus.key_pause = 1'b0;
        check("serve_ignore_lives", 16'(bus.lives), 16'h3);
        serveToPlay();

        // Divider: ticks on every second edge, phase kept across pause
        ticks = 0;
        repeat (4) vsEdge();
        check("ticks_4", 16'(ticks), 16'h2);
        bus.key_pause = 1'b1;
        step();
        bus.key_pause = 1'b0;
        check("paused", 16'(bus.state), 16'h3);
        repeat (3) vsEdge();
        check("ticks_paused", 16'(ticks), 16'h2);
        bus.key_pause = 1'b1;
        step();
        bus.key_pause = 1'b0;
        check("resumed", 16'(bus.state), 16'h2);
        vsEdge();
        check("phase_kept", 16'(ticks), 16'h2);
        repeat (5) vsEdge();
        check("ticks_10", 16'(ticks), 16'h5);

        // Reset mid-play
        hits(42);
        check("score_42", bus.score_bcd, 16'h0042);
        #2 reset = 1'b0;
        step();
        check("mid_rst_state", 16'(bus.state), 16'h0);
        check("mid_rst_lives", 16'(bus.lives), 16'h0);
        check("mid_rst_score", bus.score_bcd, 16'h0000);
        check("mid_rst_tick", 16'(bus.move_tick), 16'h0);
        reset = 1'b1;
        step();

        startGame();
        serveToPlay();
        hits(99);
        check("score_99", bus.score_bcd, 16'h0099);
        bus.ball_lost = 1'b1;
        step();
        bus.ball_lost = 1'b0;
        check("lost_state", 16'(bus.state), 16'h1);
        check("lost_lives", 16'(bus.lives), 16'h2);
        check("lost_load", 16'(bus.serve_load), 16'h1);
        serveToPlay();
        hits(1);
        check("score_100", bus.score_bcd, 16'h0100);
`ifdef EXTRA_LIFE_EN
        expLives = 2'd3;
`else
        expLives = 2'd2;
`endif
        check("lives_100", 16'(bus.lives), 16'(expLives));

        // Bring lives down to one
        while (expLives > 2'd1) begin
            bus.ball_lost = 1'b1;
            step();
            bus.ball_lost = 1'b0;
            expLives = expLives - 2'd1;
            check("dec_lives", 16'(bus.lives), 16'(expLives));
            serveToPlay();
        end

        // Last life lost with brick_hit and key_pause in the same cycle
        bus.ball_lost = 1'b1;
        bus.brick_hit = 1'b1;
        bus.key_pause = 1'b1;
        step();
        bus.ball_lost = 1'b0;
        bus.brick_hit = 1'b0;
        bus.key_pause = 1'b0;
        check("over_state", 16'(bus.state), 16'h4);
        check("over_end", 16'(bus.game_end), 16'h1);
        check("over_score", bus.score_bcd, 16'h0101);
        check("over_lives", 16'(bus.lives), 16'h0);
        bus.key_start = 1'b1;
        step();
        bus.key_start = 1'b0;
        check("over_idle", 16'(bus.state), 16'h0);
        check("idle_end", 16'(bus.game_end), 16'h0);

        // Saturation at 9999
        startGame();
        serveToPlay();
        hits(9999);
        check("score_9999", bus.score_bcd, 16'h9999);
        hits(1);
        check("score_sat", bus.score_bcd, 16'h9999);

        // Win
        bus.bricks_left = 6'd0;
        step();
        check("win_state", 16'(bus.state), 16'h5);
        check("win_end", 16'(bus.game_end), 16'h1);
        ticks = 0;
        repeat (4) vsEdge();
        check("win_ticks", 16'(ticks), 16'h0);
        check("win_hold", bus.score_bcd, 16'h9999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
